// File: rtl/spi_mem_ctrl_if.sv
// spi_mem_ctrl_if
//   Request/response bus between the CPU-side requester and spi_mem_ctrl.
//   master modport: requester (drives req_*, receives req_ready/resp_*)
//   slave modport : controller (receives req_*, drives req_ready/resp_*)
//   Signals:
//     req_valid  request present
//     req_ready  controller can accept; transfer when req_valid && req_ready
//     req_we     1=write, 0=read
//     req_addr   byte address (ADDR_W bits)
//     req_wdata  write byte
//     resp_valid one-cycle pulse per completed transaction
//     resp_rdata read byte, held until the next read completes
interface spi_mem_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [7:0]        req_wdata;
    logic              resp_valid;
    logic [7:0]        resp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/spi_mem_ctrl.sv
// spi_mem_ctrl
//   SPI master (mode 0, SCK = clk/2) bridging single-byte read/write requests
//   to an external SPI SRAM/flash. Each request sends {cmd, addr, data} MSB
//   first; reads return the last 8 bits sampled from spi_miso.
//   Ports:
//     clk, rst   system clock, asynchronous active-high reset
//     bus        spi_mem_ctrl_if.slave request/response bus
//     spi_cs_n   chip select, active-low
//     spi_clk    SCK, idle low
//     spi_mosi   serial data out
//     spi_miso   serial data in
//   Parameters: ADDR_W (16 or 24), CS_HIGH_CYC (>=1), CMD_READ, CMD_WRITE.
//   Optional feature macro SPI_BURST_EN: after a read, CS is kept low in a
//   HOLD state so a read of the next address costs only the 8 data bits.
module spi_mem_ctrl #(
    parameter int         ADDR_W      = 16,
    parameter int         CS_HIGH_CYC = 2,
    parameter logic [7:0] CMD_READ    = 8'h03,
    parameter logic [7:0] CMD_WRITE   = 8'h02
) (
    input  logic          clk,
    input  logic          rst,
    spi_mem_ctrl_if.slave bus,
    output logic          spi_cs_n,
    output logic          spi_clk,
    output logic          spi_mosi,
    input  logic          spi_miso
);
    localparam int NBITS = 16 + ADDR_W;
    localparam int CNT_W = $clog2(NBITS + 1);
    localparam int GAP_W = (CS_HIGH_CYC < 2) ? 1 : $clog2(CS_HIGH_CYC + 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        DONE,
        CSGAP,
        HOLD
    } state_t;

    state_t            state, state_nxt;
    // spi_mosi is the bit currently on the wire; shreg holds the bits after it
    logic [NBITS-2:0]  shreg, shreg_nxt;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
    logic              phase, phase_nxt;     // 0 = SCK low half, 1 = SCK high half
    logic [GAP_W-1:0]  gap_cnt, gap_nxt;
    logic [6:0]        rx, rx_nxt;           // previous 7 sampled MISO bits
    logic              is_rd, is_rd_nxt;
    logic              cs_n_nxt, sclk_nxt, mosi_nxt, rv_nxt;
    logic [7:0]        rdata_nxt;
    logic [NBITS-1:0]  req_frame;

`ifdef SPI_BURST_EN
    logic [ADDR_W-1:0] last_addr, last_addr_nxt;
    logic [3:0]        hold_cnt, hold_nxt;
    logic              pend, pend_nxt;      // full frame loaded while CS gap runs
    logic              seq_rd;

    assign seq_rd        = !bus.req_we && (bus.req_addr == last_addr + ADDR_W'(1));
    assign bus.req_ready = (state == IDLE) || (state == HOLD);
`else
    assign bus.req_ready = (state == IDLE);
`endif

    assign req_frame = {bus.req_we ? CMD_WRITE : CMD_READ,
                        bus.req_addr,
                        bus.req_we ? bus.req_wdata : 8'h00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            shreg          <= '0;
            bit_cnt        <= '0;
            phase          <= 1'b0;
            gap_cnt        <= '0;
            rx             <= '0;
            is_rd          <= 1'b0;
            spi_cs_n       <= 1'b1;
            spi_clk        <= 1'b0;
            spi_mosi       <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
`ifdef SPI_BURST_EN
            last_addr      <= '0;
            hold_cnt       <= '0;
            pend           <= 1'b0;
`endif
        end else begin
            state          <= state_nxt;
            shreg          <= shreg_nxt;
            bit_cnt        <= bit_cnt_nxt;
            phase          <= phase_nxt;
            gap_cnt        <= gap_nxt;
            rx             <= rx_nxt;
            is_rd          <= is_rd_nxt;
            spi_cs_n       <= cs_n_nxt;
            spi_clk        <= sclk_nxt;
            spi_mosi       <= mosi_nxt;
            bus.resp_valid <= rv_nxt;
            bus.resp_rdata <= rdata_nxt;
`ifdef SPI_BURST_EN
            last_addr      <= last_addr_nxt;
            hold_cnt       <= hold_nxt;
            pend           <= pend_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        phase_nxt   = phase;
        gap_nxt     = gap_cnt;
        rx_nxt      = rx;
        is_rd_nxt   = is_rd;
        cs_n_nxt    = spi_cs_n;
        sclk_nxt    = spi_clk;
        mosi_nxt    = spi_mosi;
        rv_nxt      = 1'b0;
        rdata_nxt   = bus.resp_rdata;
`ifdef SPI_BURST_EN
        last_addr_nxt = last_addr;
        hold_nxt      = hold_cnt;
        pend_nxt      = pend;
`endif

        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    mosi_nxt    = req_frame[NBITS-1];
                    shreg_nxt   = req_frame[NBITS-2:0];
                    bit_cnt_nxt = CNT_W'(NBITS);
                    phase_nxt   = 1'b0;
                    is_rd_nxt   = !bus.req_we;
                    cs_n_nxt    = 1'b0;
                    sclk_nxt    = 1'b0;
                    state_nxt   = SHIFT;
`ifdef SPI_BURST_EN
                    last_addr_nxt = bus.req_addr;
`endif
                end
            end

            SHIFT: begin
                if (!phase) begin
                    sclk_nxt  = 1'b1;
                    phase_nxt = 1'b1;
                end else begin
                    // Edge ending the high half: sample MISO, advance MOSI.
                    sclk_nxt    = 1'b0;
                    phase_nxt   = 1'b0;
                    rx_nxt      = {rx[5:0], spi_miso};
                    shreg_nxt   = {shreg[NBITS-3:0], 1'b0};
                    mosi_nxt    = shreg[NBITS-2];
                    bit_cnt_nxt = bit_cnt - CNT_W'(1);
                    if (bit_cnt == CNT_W'(1)) begin
                        mosi_nxt  = 1'b0;
                        cs_n_nxt  = 1'b1;
                        rv_nxt    = 1'b1;
                        state_nxt = DONE;
                        if (is_rd) begin
                            rdata_nxt = {rx, spi_miso};
`ifdef SPI_BURST_EN
                            cs_n_nxt  = 1'b0;
`endif
                        end
                    end
                end
            end

            DONE: begin
`ifdef SPI_BURST_EN
                if (is_rd) begin
                    hold_nxt  = '0;
                    state_nxt = HOLD;
                end else
`endif
                if (CS_HIGH_CYC < 2) begin
                    state_nxt = IDLE;
                end else begin
                    // DONE already counts as one CS-high cycle.
                    gap_nxt   = GAP_W'(CS_HIGH_CYC - 2);
                    state_nxt = CSGAP;
                end
            end

            CSGAP: begin
                if (gap_cnt == '0) begin
                    state_nxt = IDLE;
`ifdef SPI_BURST_EN
                    if (pend) begin
                        // Frame and first MOSI bit were loaded when accepted in HOLD.
                        pend_nxt  = 1'b0;
                        cs_n_nxt  = 1'b0;
                        sclk_nxt  = 1'b0;
                        phase_nxt = 1'b0;
                        state_nxt = SHIFT;
                    end
`endif
                end else begin
                    gap_nxt = gap_cnt - GAP_W'(1);
                end
            end

`ifdef SPI_BURST_EN
            HOLD: begin
                if (bus.req_valid) begin
                    last_addr_nxt = bus.req_addr;
                    phase_nxt     = 1'b0;
                    is_rd_nxt     = !bus.req_we;
                    if (seq_rd) begin
                        // CS still low: clock out only the data byte.
                        mosi_nxt    = 1'b0;
                        shreg_nxt   = '0;
                        bit_cnt_nxt = CNT_W'(8);
                        state_nxt   = SHIFT;
                    end else begin
                        mosi_nxt    = req_frame[NBITS-1];
                        shreg_nxt   = req_frame[NBITS-2:0];
                        bit_cnt_nxt = CNT_W'(NBITS);
                        pend_nxt    = 1'b1;
                        cs_n_nxt    = 1'b1;
                        gap_nxt     = GAP_W'(CS_HIGH_CYC - 1);
                        state_nxt   = CSGAP;
                    end
                end else if (hold_cnt == 4'd15) begin
                    cs_n_nxt  = 1'b1;
                    gap_nxt   = GAP_W'(CS_HIGH_CYC - 1);
                    state_nxt = CSGAP;
                end else begin
                    hold_nxt = hold_cnt + 4'd1;
                end
            end
`endif

            default: state_nxt = IDLE;
        endcase
    end
endmodule
